// File: rtl/tick_scheduler.sv
// Shared prescaler driving four programmable tick channels, configured one
// channel at a time through a two-state valid/ready sequencer.
module tick_scheduler #(
    parameter int PRESCALE = 50000,
    parameter int PW       = 16,
    parameter int CW       = 8
) (
    input  logic          clk1,
    input  logic          rst_n,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [1:0]    cfg_ch,
    input  logic          cfg_en,
    input  logic          cfg_mode,
    input  logic [CW-1:0] cfg_period,
    output logic          base_tick,
    output logic [3:0]    tick,
    output logic [3:0]    clk_out,
    output logic [3:0]    busy
);

    typedef enum logic {IDLE, APPLY} state_t;

    state_t        state_reg;
    logic          cfg_ready_reg;
    logic [1:0]    lat_ch_reg;
    logic          lat_en_reg;
    logic          lat_mode_reg;
    logic [CW-1:0] lat_period_reg;

    logic [PW-1:0] presc_reg;
    logic [3:0]    busy_next;
    logic          any_busy;
    logic          apply;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cfg_ready_reg  <= 1'b1;
            lat_ch_reg     <= '0;
            lat_en_reg     <= 1'b0;
            lat_mode_reg   <= 1'b0;
            lat_period_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cfg_valid && cfg_ready_reg) begin
                        lat_ch_reg     <= cfg_ch;
                        lat_en_reg     <= cfg_en;
                        lat_mode_reg   <= cfg_mode;
                        lat_period_reg <= cfg_period;
                        state_reg      <= APPLY;
                        cfg_ready_reg  <= 1'b0;
                    end
                end
                APPLY: begin
                    state_reg     <= IDLE;
                    cfg_ready_reg <= 1'b1;
                end
                default: begin
                    state_reg     <= IDLE;
                    cfg_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign cfg_ready = cfg_ready_reg;
    assign apply     = (state_reg == APPLY);
    assign any_busy  = |busy;
    assign base_tick = any_busy && (presc_reg == PW'(PRESCALE - 1));

    // Looking at next-cycle busy lets a disable of the last channel clear the
    // prescaler on the same edge, so a later enable always starts from phase 0.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            presc_reg <= '0;
        end else if (busy_next == 4'b0000 || base_tick) begin
            presc_reg <= '0;
        end else if (any_busy) begin
            presc_reg <= presc_reg + PW'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ch
            logic [CW-1:0] cnt_reg, cnt_next;
            logic [CW-1:0] period_reg, period_next;
            logic          mode_reg, mode_next;
            logic          busy_reg, busy_nx;
            logic          clk_reg, clk_next;
            logic          tick_reg, tick_next;
            logic          hit;

            assign hit = apply && (lat_ch_reg == 2'(gi));

            // A config write takes priority over a coincident base tick.
            always_comb begin
                cnt_next    = cnt_reg;
                period_next = period_reg;
                mode_next   = mode_reg;
                busy_nx     = busy_reg;
                clk_next    = clk_reg;
                tick_next   = 1'b0;
                if (hit) begin
                    if (lat_en_reg && lat_period_reg != '0) begin
                        cnt_next    = lat_period_reg - CW'(1);
                        period_next = lat_period_reg;
                        mode_next   = lat_mode_reg;
                        busy_nx     = 1'b1;
                    end else begin
                        cnt_next = '0;
                        busy_nx  = 1'b0;
                        clk_next = 1'b0;
                    end
                end else if (base_tick && busy_reg) begin
                    if (cnt_reg != '0) begin
                        cnt_next = cnt_reg - CW'(1);
                    end else begin
                        tick_next = 1'b1;
                        clk_next  = ~clk_reg;
                        if (mode_reg) begin
                            busy_nx = 1'b0;
                        end else begin
                            cnt_next = period_reg - CW'(1);
                        end
                    end
                end
            end

            always_ff @(posedge clk1 or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg    <= '0;
                    period_reg <= '0;
                    mode_reg   <= 1'b0;
                    busy_reg   <= 1'b0;
                    clk_reg    <= 1'b0;
                    tick_reg   <= 1'b0;
                end else begin
                    cnt_reg    <= cnt_next;
                    period_reg <= period_next;
                    mode_reg   <= mode_next;
                    busy_reg   <= busy_nx;
                    clk_reg    <= clk_next;
                    tick_reg   <= tick_next;
                end
            end

            assign busy_next[gi] = busy_nx;
            assign busy[gi]      = busy_reg;
            assign clk_out[gi]   = clk_reg;
            assign tick[gi]      = tick_reg;
        end
    endgenerate

endmodule

// File: tb/tb_tick_scheduler.sv
// Randomized and scenario bench for tick_scheduler, compared cycle by cycle
// against a behavioural model that counts remaining base ticks per channel.
module tb_tick_scheduler;
    localparam int PRESCALE = 4;
    localparam int PW       = 3;
    localparam int CW       = 8;

    logic          clk1;
    logic          rst_n;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [1:0]    cfg_ch;
    logic          cfg_en;
    logic          cfg_mode;
    logic [CW-1:0] cfg_period;
    logic          base_tick;
    logic [3:0]    tick;
    logic [3:0]    clk_out;
    logic [3:0]    busy;

    tick_scheduler #(.PRESCALE(PRESCALE), .PW(PW), .CW(CW)) dut (
        .clk1(clk1), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_en(cfg_en), .cfg_mode(cfg_mode), .cfg_period(cfg_period),
        .base_tick(base_tick), .tick(tick), .clk_out(clk_out), .busy(busy)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: m_rem counts base ticks still to go before expiry.
    bit m_ready;
    int m_lch, m_lper;
    bit m_len, m_lmode;
    bit m_busy[4], m_mode[4], m_clk[4], m_tick[4];
    int m_rem[4], m_per[4];
    int m_phase;

    function automatic bit m_any();
        return m_busy[0] | m_busy[1] | m_busy[2] | m_busy[3];
    endfunction

    function automatic logic [3:0] pack(input bit v[4]);
        return {v[3], v[2], v[1], v[0]};
    endfunction

    task automatic model_reset();
        m_ready = 1; m_lch = 0; m_lper = 0; m_len = 0; m_lmode = 0; m_phase = 0;
        for (int c = 0; c < 4; c++) begin
            m_busy[c] = 0; m_mode[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
            m_rem[c] = 0; m_per[c] = 0;
        end
    endtask

    task automatic model_edge();
        bit any_old, bt, apply;
        any_old = m_any();
        bt      = any_old && (m_phase == PRESCALE - 1);
        apply   = !m_ready;
        for (int c = 0; c < 4; c++) begin
            m_tick[c] = 0;
            if (apply && m_lch == c) begin
                if (m_len && m_lper != 0) begin
                    m_busy[c] = 1; m_rem[c] = m_lper; m_per[c] = m_lper; m_mode[c] = m_lmode;
                end else begin
                    m_busy[c] = 0; m_clk[c] = 0;
                end
            end else if (bt && m_busy[c]) begin
                m_rem[c]--;
                if (m_rem[c] == 0) begin
                    m_tick[c] = 1;
                    m_clk[c]  = ~m_clk[c];
                    if (m_mode[c]) m_busy[c] = 0;
                    else           m_rem[c]  = m_per[c];
                end
            end
        end
        if (!m_any() || bt) m_phase = 0;
        else if (any_old)   m_phase++;
        if (m_ready) begin
            if (cfg_valid) begin
                m_lch = int'(cfg_ch); m_len = cfg_en; m_lmode = cfg_mode;
                m_lper = int'(cfg_period); m_ready = 0;
            end
        end else begin
            m_ready = 1;
        end
    endtask

    task automatic compare_all();
        check("cfg_ready", {31'd0, cfg_ready}, {31'd0, m_ready});
        check("base_tick", {31'd0, base_tick}, {31'd0, (m_any() && m_phase == PRESCALE - 1)});
        check("busy", {28'd0, busy}, {28'd0, pack(m_busy)});
        check("clk_out", {28'd0, clk_out}, {28'd0, pack(m_clk)});
        check("tick", {28'd0, tick}, {28'd0, pack(m_tick)});
    endtask

    task automatic step();
        @(posedge clk1);
        model_edge();
        @(negedge clk1);
        cyc++;
        compare_all();
    endtask

    int tq[$];
    bit cq[$];
    bit bq[$];

    task automatic run(input int n, input int ch);
        repeat (n) begin
            step();
            if (tick[ch]) begin
                tq.push_back(cyc); cq.push_back(clk_out[ch]); bq.push_back(busy[ch]);
            end
        end
    endtask

    // Issues one config; apply_cyc is the cycle index right after the APPLY edge.
    task automatic send(input int ch, input bit en, input bit mode, input int per,
                        output int apply_cyc);
        int guard = 0;
        while (!m_ready && guard < 4) begin step(); guard++; end
        cfg_valid = 1; cfg_ch = 2'(ch); cfg_en = en; cfg_mode = mode; cfg_period = CW'(per);
        step();
        cfg_valid = 0;
        apply_cyc = cyc + 1;
    endtask

    initial begin
        int a, acc, guard, bt_cnt;
        bit found;
        bit exp_rdy[4] = '{1, 0, 1, 0};
        rst_n = 0; cfg_valid = 0; cfg_ch = 0; cfg_en = 0; cfg_mode = 0; cfg_period = 0;
        model_reset();
        @(negedge clk1);
        compare_all();
        rst_n = 1;

        // Periodic channel 0, period 3: ticks every 12 cycles, clk_out toggles each tick.
        send(0, 1, 0, 3, a);
        tq.delete(); cq.delete(); bq.delete();
        run(60, 0);
        check("per_count", tq.size(), 4);
        if (tq.size() >= 4) begin
            check("per_first", tq[0] - a, 12);
            for (int i = 1; i < 4; i++) check("per_interval", tq[i] - tq[i-1], 12);
            check("per_clk0", {31'd0, cq[0]}, 1);
            check("per_clk1", {31'd0, cq[1]}, 0);
        end
        send(0, 0, 0, 0, a);
        step();

        // One-shot channel 2, period 2: single tick 8 cycles after apply.
        send(2, 1, 1, 2, a);
        tq.delete(); cq.delete(); bq.delete();
        run(40, 2);
        check("os_count", tq.size(), 1);
        if (tq.size() >= 1) begin
            check("os_time", tq[0] - a, 8);
            check("os_busy_drop", {31'd0, bq[0]}, 0);
        end

        // Handshake: valid held four cycles gives ready 1,0,1,0 and two accepts.
        acc = 0;
        cfg_valid = 1; cfg_ch = 3; cfg_en = 1; cfg_mode = 0; cfg_period = 3;
        for (int i = 0; i < 4; i++) begin
            check("hs_ready", {31'd0, cfg_ready}, {31'd0, exp_rdy[i]});
            if (cfg_valid && cfg_ready) acc++;
            step();
        end
        cfg_valid = 0;
        check("hs_accepts", acc, 2);

        // Collision: reconfigure ch1 so APPLY meets a base tick with its counter at 0.
        send(1, 1, 0, 2, a);
        found = 0; guard = 0;
        while (!found && guard < 200) begin
            if (m_ready && m_busy[1] && m_rem[1] == 1 && m_phase == PRESCALE - 2) found = 1;
            else begin step(); guard++; end
        end
        check("coll_found", {31'd0, found}, 1);
        if (found) begin
            cfg_valid = 1; cfg_ch = 1; cfg_en = 1; cfg_mode = 0; cfg_period = 5;
            step();
            cfg_valid = 0;
            check("coll_bt", {31'd0, base_tick}, 1);
            step();
            check("coll_no_tick", {31'd0, tick[1]}, 0);
            a = cyc;
            tq.delete(); cq.delete(); bq.delete();
            run(40, 1);
            check("coll_next", (tq.size() > 0) ? tq[0] - a : -1, 20);
        end

        // Disable: period 0 on the only running channel stops the prescaler.
        send(3, 0, 0, 0, a);
        guard = 0;
        while (clk_out[1] !== 1'b1 && guard < 100) begin step(); guard++; end
        check("dis_wait", {31'd0, clk_out[1]}, 1);
        send(1, 1, 0, 0, a);
        step();
        check("dis_busy", {31'd0, busy[1]}, 0);
        check("dis_clk", {31'd0, clk_out[1]}, 0);
        bt_cnt = 0;
        repeat (20) begin step(); bt_cnt += int'(base_tick); end
        check("dis_no_base", bt_cnt, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cfg_valid  = ($urandom_range(0, 2) == 0);
            cfg_ch     = 2'($urandom_range(0, 3));
            cfg_en     = ($urandom_range(0, 3) != 0);
            cfg_mode   = ($urandom_range(0, 3) == 0);
            cfg_period = CW'($urandom_range(0, 6));
            step();
        end
        cfg_valid = 0;
        guard = 0;
        while (!m_any() && guard < 20) begin
            cfg_valid = 1; cfg_ch = 0; cfg_en = 1; cfg_mode = 0; cfg_period = 2;
            step(); guard++;
        end
        cfg_valid = 0;
        run(5, 0);

        // Asynchronous reset between clock edges.
        #2;
        rst_n = 0;
        #1;
        check("rst_busy", {28'd0, busy}, 0);
        check("rst_clk", {28'd0, clk_out}, 0);
        check("rst_tick", {28'd0, tick}, 0);
        check("rst_ready", {31'd0, cfg_ready}, 1);
        check("rst_base", {31'd0, base_tick}, 0);
        model_reset();
        @(negedge clk1);
        rst_n = 1;
        compare_all();
        run(10, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
